parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Barrier controller for a single-entry, single-exit parking lot. It accepts driver requests at the entry and exit barriers and opens a barrier only when the lot state allows it. It closes each barrier when the lane sensor FSM reports a completed passage (entering/exiting pulse), or when a timeout expires. It owns the occupancy count and reserves a slot while the entry barrier is open, so the lot cannot be oversubscribed.

Parameters:
CAPACITY, 16, number of parking spaces (>=1)
CNT_W, 5, occupancy width; must hold CAPACITY
TIMEOUT, 200, max cycles a barrier stays open without a passage (>=2)
TO_W, 8, timer width; must hold TIMEOUT-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
entry_req  input  1  driver request at entry (level or pulse)
exit_req  input  1  driver request at exit (level or pulse)
entering  input  1  1-cycle pulse from entry-lane sensor FSM: car fully entered
exiting  input  1  1-cycle pulse from exit-lane sensor FSM: car fully exited
entry_gate_open  output  1  entry barrier drive, registered
exit_gate_open  output  1  exit barrier drive, registered
occupancy  output  CNT_W  cars inside, registered
full  output  1  occupancy + entry_gate_open >= CAPACITY
empty  output  1  occupancy == 0
entry_denied  output  1  1-cycle pulse, entry request refused (full)
exit_denied  output  1  1-cycle pulse, exit request refused (empty)
entry_timeout  output  1  1-cycle pulse, entry barrier closed by timeout
exit_timeout  output  1  1-cycle pulse, exit barrier closed by timeout

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: both gates 0, occupancy 0, all pulse outputs 0, both FSMs IDLE, timers 0. After reset: full=0, empty=1.
- full and empty are decoded combinationally from registered state only. There is no combinational path from any input to any output.
- Entry FSM, states E_IDLE and E_OPEN:
  - E_IDLE with entry_req=1 and full=0: go to E_OPEN. entry_gate_open=1 from the next cycle. Timer cleared.
  - E_IDLE with entry_req=1 and full=1: stay in E_IDLE. entry_denied pulses for 1 cycle. While entry_req is held, it re-pulses every cycle.
  - E_OPEN with entering=1: go to E_IDLE. Gate drops next cycle.
  - E_OPEN, no entering, timer==TIMEOUT-1: go to E_IDLE and pulse entry_timeout. Otherwise the timer increments.
  - entering and timeout in the same cycle: entering wins, no timeout pulse.
  - entry_req is ignored while in E_OPEN.
- Exit FSM, states X_IDLE and X_OPEN: identical structure using exit_req, exiting, exit_gate_open, exit_denied and exit_timeout. The refusal condition is empty=1 instead of full=1.
- Occupancy update, effective the cycle after the pulse:
  - +1 on entering, -1 on exiting.
  - Both in the same cycle: unchanged.
  - Pulses are counted even when the corresponding FSM is IDLE, because the sensor is authoritative (tailgating).
  - Saturates at CAPACITY (increment dropped) and at 0 (decrement dropped).
- Reservation: an open entry gate counts toward full. Example: with CAPACITY-1 cars inside and the entry gate open, full=1. A second entry request is therefore denied even before the car passes. On an entry timeout the reservation is released.
- The exit decision uses occupancy only. The pending entry reservation does not make the lot non-empty.
- Both FSMs run independently. Simultaneous entry and exit requests are both served in the same cycle.
- Reset mid-operation: gates close, occupancy clears and pulses are suppressed in the reset cycle. Sensor pulses arriving during reset are discarded.

Test Plan:
1. Bench uses CAPACITY=2, TIMEOUT=4. Reset, then entry_req 1 cycle -> entry_gate_open=1 next cycle, full=0. entering pulse -> gate 0 and occupancy=1 next cycle, empty=0.
2. With occupancy=1, open the entry gate -> full=1. A second entry_req while open is ignored. After entering: occupancy=2, full=1. A further entry_req -> entry_denied 1-cycle pulse, gate stays 0.
3. Entry gate opened, no entering for 4 cycles -> gate drops after the 4th open cycle, entry_timeout pulses once, occupancy unchanged. Repeat with entering on the 4th cycle -> no timeout, occupancy+1.
4. Occupancy=0, exit_req -> exit_denied pulse, exit gate stays 0. Then an unsolicited exiting pulse -> occupancy stays 0. An unsolicited entering pulse -> occupancy=1.
5. Occupancy=1, entry and exit gates open together, entering and exiting in the same cycle -> both gates 0 next cycle, occupancy stays 1. At occupancy=2 (saturated), an extra entering pulse -> occupancy stays 2.
6. Assert reset with both gates open and occupancy=2 -> next cycle all outputs at reset values. An entering pulse during reset is not counted.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Barrier controller for a single-entry, single-exit parking lot. Two
// independent two-state FSMs drive the entry and exit barriers. The occupancy
// counter follows the lane sensor pulses. An open entry barrier reserves a slot,
// so the lot cannot be oversubscribed while a car is still driving in.
//
// Ports
//   clk_i              system clock, all logic on the rising edge
//   reset_i            synchronous, active-high reset
//   entry_req_i        driver request at the entry barrier (level or pulse)
//   exit_req_i         driver request at the exit barrier (level or pulse)
//   entering_i         1-cycle pulse from the entry lane sensor: car fully entered
//   exiting_i          1-cycle pulse from the exit lane sensor: car fully exited
//   entry_gate_open_o  entry barrier drive (registered)
//   exit_gate_open_o   exit barrier drive (registered)
//   occupancy_o        cars inside (registered)
//   full_o             occupancy + open entry reservation >= CAPACITY
//   empty_o            occupancy == 0
//   entry_denied_o     1-cycle pulse, entry request refused because the lot is full
//   exit_denied_o      1-cycle pulse, exit request refused because the lot is empty
//   entry_timeout_o    1-cycle pulse, entry barrier closed by timeout
//   exit_timeout_o     1-cycle pulse, exit barrier closed by timeout
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
  parameter int CAPACITY = 16,   // parking spaces, >= 1
  parameter int CNT_W    = 5,    // must hold CAPACITY
  parameter int TIMEOUT  = 200,  // max open cycles without a passage, >= 2
  parameter int TO_W     = 8     // must hold TIMEOUT-1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             entry_req_i,
  input  logic             exit_req_i,
  input  logic             entering_i,
  input  logic             exiting_i,
  output logic             entry_gate_open_o,
  output logic             exit_gate_open_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             entry_denied_o,
  output logic             exit_denied_o,
  output logic             entry_timeout_o,
  output logic             exit_timeout_o
);

  localparam logic [CNT_W-1:0] CAP_OCC = CNT_W'(CAPACITY);
  localparam logic [CNT_W:0]   CAP_EXT = (CNT_W+1)'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic {E_IDLE, E_OPEN} entry_state_e;
  typedef enum logic {X_IDLE, X_OPEN} exit_state_e;

  entry_state_e    entry_state_q;
  exit_state_e     exit_state_q;
  logic [TO_W-1:0] entry_timer_q, exit_timer_q;
  logic            entry_gate_q, exit_gate_q;
  logic            entry_denied_q, exit_denied_q;
  logic            entry_timeout_q, exit_timeout_q;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;

  // Status decoded from registered state only, so no input reaches an output
  // combinationally. One extra bit so occupancy + reservation cannot wrap.
  logic [CNT_W:0] committed;
  logic           full, empty;

  assign committed = {1'b0, occupancy_q} + {{CNT_W{1'b0}}, entry_gate_q};
  assign full      = committed >= CAP_EXT;
  assign empty     = (occupancy_q == '0);

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  // NOTE: state is written with <= so every register samples the pre-edge values
  // of every other register, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      entry_state_q   <= E_IDLE;
      entry_timer_q   <= '0;
      entry_gate_q    <= 1'b0;
      entry_denied_q  <= 1'b0;
      entry_timeout_q <= 1'b0;
    end else begin
      entry_denied_q  <= 1'b0;
      entry_timeout_q <= 1'b0;
      case (entry_state_q)
        E_IDLE: begin
          if (entry_req_i) begin
            if (full) begin
              // A held request re-pulses every cycle while the lot stays full.
              entry_denied_q <= 1'b1;
            end else begin
              entry_state_q <= E_OPEN;
              entry_gate_q  <= 1'b1;
              entry_timer_q <= '0;
            end
          end
        end
        E_OPEN: begin
          // A passage takes priority over a timeout in the same cycle.
          if (entering_i) begin
            entry_state_q <= E_IDLE;
            entry_gate_q  <= 1'b0;
          end else if (entry_timer_q == TO_LAST) begin
            entry_state_q   <= E_IDLE;
            entry_gate_q    <= 1'b0;
            entry_timeout_q <= 1'b1;
          end else begin
            entry_timer_q <= entry_timer_q + 1'b1;
          end
        end
        default: entry_state_q <= E_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Exit FSM (same structure; refusal when the lot is empty)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exit_state_q   <= X_IDLE;
      exit_timer_q   <= '0;
      exit_gate_q    <= 1'b0;
      exit_denied_q  <= 1'b0;
      exit_timeout_q <= 1'b0;
    end else begin
      exit_denied_q  <= 1'b0;
      exit_timeout_q <= 1'b0;
      case (exit_state_q)
        X_IDLE: begin
          if (exit_req_i) begin
            // The pending entry reservation does not count as a car inside.
            if (empty) begin
              exit_denied_q <= 1'b1;
            end else begin
              exit_state_q <= X_OPEN;
              exit_gate_q  <= 1'b1;
              exit_timer_q <= '0;
            end
          end
        end
        X_OPEN: begin
          if (exiting_i) begin
            exit_state_q <= X_IDLE;
            exit_gate_q  <= 1'b0;
          end else if (exit_timer_q == TO_LAST) begin
            exit_state_q   <= X_IDLE;
            exit_gate_q    <= 1'b0;
            exit_timeout_q <= 1'b1;
          end else begin
            exit_timer_q <= exit_timer_q + 1'b1;
          end
        end
        default: exit_state_q <= X_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy: sensors are authoritative, so pulses count even when the
  // matching barrier is closed (tailgating). Saturates at 0 and CAPACITY.
  // ---------------------------------------------------------------------------
  // NOTE: occupancy_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    occupancy_d = occupancy_q;
    if (entering_i && !exiting_i && (occupancy_q < CAP_OCC)) begin
      occupancy_d = occupancy_q + 1'b1;
    end else if (exiting_i && !entering_i && (occupancy_q != '0)) begin
      occupancy_d = occupancy_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign entry_gate_open_o = entry_gate_q;
  assign exit_gate_open_o  = exit_gate_q;
  assign occupancy_o       = occupancy_q;
  assign full_o            = full;
  assign empty_o           = empty;
  assign entry_denied_o    = entry_denied_q;
  assign exit_denied_o     = exit_denied_q;
  assign entry_timeout_o   = entry_timeout_q;
  assign exit_timeout_o    = exit_timeout_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
//
// Self-checking bench for parking_gate_ctrl with CAPACITY=2, TIMEOUT=4.
// Directed vector table, hand-written timeout sequences, then random traffic
// compared against a lot-level reference model.
// -----------------------------------------------------------------------------
module tb_parking_gate_ctrl;

  localparam int CAP = 2;
  localparam int TO  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req = 1'b0, exit_req = 1'b0;
  logic       entering = 1'b0, exiting = 1'b0;
  logic       entry_gate_open, exit_gate_open;
  logic [1:0] occupancy;
  logic       full, empty;
  logic       entry_denied, exit_denied, entry_timeout, exit_timeout;

  parking_gate_ctrl #(
    .CAPACITY(CAP),
    .CNT_W   (2),
    .TIMEOUT (TO),
    .TO_W    (2)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .entry_req_i      (entry_req),
    .exit_req_i       (exit_req),
    .entering_i       (entering),
    .exiting_i        (exiting),
    .entry_gate_open_o(entry_gate_open),
    .exit_gate_open_o (exit_gate_open),
    .occupancy_o      (occupancy),
    .full_o           (full),
    .empty_o          (empty),
    .entry_denied_o   (entry_denied),
    .exit_denied_o    (exit_denied),
    .entry_timeout_o  (entry_timeout),
    .exit_timeout_o   (exit_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       eg;
    logic       xg;
    logic [1:0] occ;
    logic       full;
    logic       empty;
    logic       ed;
    logic       xd;
    logic       et;
    logic       xt;
  } out_t;

  typedef struct {
    logic rst, er, xr, en, ex;
    out_t exp;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic out_t mk(logic eg, logic xg, logic [1:0] occ, logic fl,
                              logic em, logic ed, logic xd, logic et, logic xt);
    out_t o;
    o.eg = eg; o.xg = xg; o.occ = occ; o.full = fl; o.empty = em;
    o.ed = ed; o.xd = xd; o.et = et; o.xt = xt;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(entry_gate_open, exit_gate_open, occupancy, full, empty,
              entry_denied, exit_denied, entry_timeout, exit_timeout);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got eg,xg,occ,full,empty,ed,xd,et,xt=%b required %b",
               name, act, exp);
    end
  endtask

  // Inputs change #1 after the edge; outputs are sampled #1 after the next edge.
  task automatic step(input logic rst, input logic er, input logic xr,
                      input logic en, input logic ex);
    reset = rst; entry_req = er; exit_req = xr; entering = en; exiting = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic er, input logic xr,
                     input logic en, input logic ex, input out_t exp);
    vec_t v;
    v.rst = rst; v.er = er; v.xr = xr; v.en = en; v.ex = ex; v.exp = exp;
    vq.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the lot described as car count plus "how long has each
  // barrier been open", advanced one clock at a time.
  // ---------------------------------------------------------------------------
  int m_occ;
  int m_eage, m_xage;   // cycles the barrier has been up, 0 = closed
  bit m_ed, m_xd, m_et, m_xt;

  task automatic model_step(input bit rst, input bit er, input bit xr,
                            input bit en, input bit ex);
    bit lot_full, lot_empty;
    if (rst) begin
      m_occ = 0; m_eage = 0; m_xage = 0;
      m_ed = 0; m_xd = 0; m_et = 0; m_xt = 0;
      return;
    end
    lot_full  = (m_occ + ((m_eage > 0) ? 1 : 0)) >= CAP;
    lot_empty = (m_occ == 0);
    m_ed = 0; m_xd = 0; m_et = 0; m_xt = 0;

    if (m_eage == 0) begin
      if (er && lot_full) m_ed = 1;
      else if (er)        m_eage = 1;
    end else if (en)        m_eage = 0;
    else if (m_eage == TO) begin m_eage = 0; m_et = 1; end
    else                    m_eage++;

    if (m_xage == 0) begin
      if (xr && lot_empty) m_xd = 1;
      else if (xr)         m_xage = 1;
    end else if (ex)         m_xage = 0;
    else if (m_xage == TO) begin m_xage = 0; m_xt = 1; end
    else                     m_xage++;

    if (en && !ex && m_occ < CAP) m_occ++;
    if (ex && !en && m_occ > 0)   m_occ--;
  endtask

  function automatic out_t model_out();
    int res;
    res = m_occ + ((m_eage > 0) ? 1 : 0);
    return mk(m_eage > 0, m_xage > 0, 2'(m_occ), res >= CAP, m_occ == 0,
              m_ed, m_xd, m_et, m_xt);
  endfunction

  initial begin
    // rst er xr en ex  | eg xg occ full empty ed xd et xt
    add(1,0,0,0,0, mk(0,0,0,0,1,0,0,0,0)); // reset
    add(0,1,0,0,0, mk(1,0,0,0,1,0,0,0,0)); // entry opens, reservation not full
    add(0,0,0,0,0, mk(1,0,0,0,1,0,0,0,0));
    add(0,0,0,1,0, mk(0,0,1,0,0,0,0,0,0)); // car in
    add(0,1,0,0,0, mk(1,0,1,1,0,0,0,0,0)); // reservation makes lot full
    add(0,1,0,0,0, mk(1,0,1,1,0,0,0,0,0)); // request ignored while open
    add(0,0,0,1,0, mk(0,0,2,1,0,0,0,0,0));
    add(0,1,0,0,0, mk(0,0,2,1,0,1,0,0,0)); // denied
    add(0,1,0,0,0, mk(0,0,2,1,0,1,0,0,0)); // held request re-pulses
    add(0,0,0,0,0, mk(0,0,2,1,0,0,0,0,0));
    add(0,0,1,0,0, mk(0,1,2,1,0,0,0,0,0)); // exit opens
    add(0,0,0,0,1, mk(0,0,1,0,0,0,0,0,0));
    add(0,0,1,0,0, mk(0,1,1,0,0,0,0,0,0));
    add(0,0,0,0,1, mk(0,0,0,0,1,0,0,0,0));
    add(0,0,1,0,0, mk(0,0,0,0,1,0,1,0,0)); // exit denied when empty
    add(0,0,0,0,1, mk(0,0,0,0,1,0,0,0,0)); // unsolicited exit floors at 0
    add(0,0,0,1,0, mk(0,0,1,0,0,0,0,0,0)); // tailgate counted
    add(0,1,1,0,0, mk(1,1,1,1,0,0,0,0,0)); // both gates together
    add(0,0,0,1,1, mk(0,0,1,0,0,0,0,0,0)); // both pulses cancel
    add(0,0,0,1,0, mk(0,0,2,1,0,0,0,0,0));
    add(0,0,0,1,0, mk(0,0,2,1,0,0,0,0,0)); // saturates at CAPACITY
    add(0,0,1,0,0, mk(0,1,2,1,0,0,0,0,0));
    add(1,0,0,1,0, mk(0,0,0,0,1,0,0,0,0)); // reset, entering discarded
    add(0,0,0,0,0, mk(0,0,0,0,1,0,0,0,0));
    add(0,0,0,1,0, mk(0,0,1,0,0,0,0,0,0));
    add(0,1,1,0,0, mk(1,1,1,1,0,0,0,0,0));
    add(1,0,0,1,1, mk(0,0,0,0,1,0,0,0,0)); // reset with both gates open
    add(0,0,0,0,0, mk(0,0,0,0,1,0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].er, vq[i].xr, vq[i].en, vq[i].ex);
      check($sformatf("vec%0d", i), sample(), vq[i].exp);
    end

    // Entry timeout: gate up for 4 cycles, then drops with one timeout pulse.
    step(0,1,0,0,0);
    check("to_entry_open", sample(), mk(1,0,0,0,1,0,0,0,0));
    for (int k = 2; k <= TO; k++) begin
      step(0,0,0,0,0);
      check($sformatf("to_entry_hold%0d", k), sample(), mk(1,0,0,0,1,0,0,0,0));
    end
    step(0,0,0,0,0);
    check("to_entry_fire", sample(), mk(0,0,0,0,1,0,0,1,0));
    step(0,0,0,0,0);
    check("to_entry_pulse_end", sample(), mk(0,0,0,0,1,0,0,0,0));

    // Entering on the last open cycle wins over the timeout.
    step(0,1,0,0,0);
    check("race_open", sample(), mk(1,0,0,0,1,0,0,0,0));
    for (int k = 2; k <= TO; k++) begin
      step(0,0,0,0,0);
      check($sformatf("race_hold%0d", k), sample(), mk(1,0,0,0,1,0,0,0,0));
    end
    step(0,0,0,1,0);
    check("race_enter", sample(), mk(0,0,1,0,0,0,0,0,0));

    // Exit timeout leaves occupancy unchanged.
    step(0,0,1,0,0);
    check("to_exit_open", sample(), mk(0,1,1,0,0,0,0,0,0));
    for (int k = 2; k <= TO; k++) begin
      step(0,0,0,0,0);
      check($sformatf("to_exit_hold%0d", k), sample(), mk(0,1,1,0,0,0,0,0,0));
    end
    step(0,0,0,0,0);
    check("to_exit_fire", sample(), mk(0,0,1,0,0,0,0,0,1));
    step(0,0,0,0,0);
    check("to_exit_pulse_end", sample(), mk(0,0,1,0,0,0,0,0,0));

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic rst, er, xr, en, ex;
      rst = (i == 0) || ($urandom_range(99) == 0);
      er  = ($urandom_range(2) == 0);
      xr  = ($urandom_range(2) == 0);
      en  = ($urandom_range(4) == 0);
      ex  = ($urandom_range(4) == 0);
      step(rst, er, xr, en, ex);
      model_step(rst, er, xr, en, ex);
      check($sformatf("rand%0d", i), sample(), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
